// File: rtl/mdu_arbiter_pkg.sv
// Shared hardisc types for the MDU arbiter: the function field type,
// the default watchdog limit and the arbiter state encoding.
package p_hardisc;

    typedef logic [2:0] f_part;

    localparam int C_MDU_TIMEOUT = 40;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_BUSY,
        MDU_HOLD
    } mdu_state_t;

endpackage

// File: rtl/mdu_arbiter_rr.sv
// rr_pick2: combinational two-way round-robin picker.
// Ports: s_req_i[1:0] requests, s_prio_i preferred index, s_grant_o one-hot.
module rr_pick2 (
    input  logic [1:0] s_req_i,
    input  logic       s_prio_i,
    output logic [1:0] s_grant_o
);

    always_comb begin
        s_grant_o = 2'b00;
        unique case (s_req_i)
            2'b01:   s_grant_o = 2'b01;
            2'b10:   s_grant_o = 2'b10;
            2'b11:   s_grant_o = s_prio_i ? 2'b10 : 2'b01;
            default: s_grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mdu_arbiter.sv
// mdu_arbiter: shares one multi-cycle muldiv unit between two pipelines.
// Ports: per-requester req/function/operands/flush/ack in, grant/done out;
// err/result for the owner; registered compute/stall/flush/operands to muldiv.
import p_hardisc::*;

module mdu_arbiter #(
    parameter int P_TIMEOUT = C_MDU_TIMEOUT
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic [1:0]  s_req_i,
    input  f_part       s_function_i [2],
    input  logic [31:0] s_op1_i [2],
    input  logic [31:0] s_op2_i [2],
    input  logic [1:0]  s_flush_i,
    input  logic [1:0]  s_ack_i,
    output logic [1:0]  s_grant_o,
    output logic [1:0]  s_done_o,
    output logic        s_err_o,
    output logic [31:0] s_result_o,
    output logic        s_mdu_compute_o,
    output logic        s_mdu_stall_o,
    output logic        s_mdu_flush_o,
    output f_part       s_mdu_function_o,
    output logic [31:0] s_mdu_op1_o,
    output logic [31:0] s_mdu_op2_o,
    input  logic        s_mdu_finished_i,
    input  logic [31:0] s_mdu_result_i
);

    localparam int CW = $clog2(P_TIMEOUT + 1);

    mdu_state_t  state_q, state_d;
    logic        owner_q;
    logic        prio_q;
    f_part       fn_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] res_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;

    logic [1:0] elig;
    logic [1:0] pick;
    logic       own_flush;
    logic       own_ack;
    logic       timeout;

    assign elig      = s_req_i & ~s_flush_i;
    assign own_flush = s_flush_i[owner_q];
    assign own_ack   = s_ack_i[owner_q];
    assign timeout   = (cnt_q == CW'(P_TIMEOUT - 1));

    rr_pick2 u_pick (
        .s_req_i   (elig),
        .s_prio_i  (prio_q),
        .s_grant_o (pick)
    );

    always_comb begin
        state_d          = state_q;
        s_grant_o        = 2'b00;
        s_done_o         = 2'b00;
        s_err_o          = 1'b0;
        s_result_o       = 32'd0;
        s_mdu_compute_o  = 1'b0;
        s_mdu_flush_o    = 1'b0;
        s_mdu_function_o = '0;
        s_mdu_op1_o      = 32'd0;
        s_mdu_op2_o      = 32'd0;
        s_mdu_stall_o    = (state_q != MDU_BUSY);
        unique case (state_q)
            MDU_IDLE: begin
                s_grant_o = pick;
                if (|pick) state_d = MDU_BUSY;
            end
            MDU_BUSY: begin
                s_mdu_compute_o  = 1'b1;
                s_mdu_function_o = fn_q;
                s_mdu_op1_o      = op1_q;
                s_mdu_op2_o      = op2_q;
                if (own_flush) begin
                    s_mdu_flush_o = 1'b1;
                    state_d       = MDU_IDLE;
                end else if (s_mdu_finished_i) begin
                    state_d = MDU_HOLD;
                end else if (timeout) begin
                    s_mdu_flush_o = 1'b1;
                    state_d       = MDU_HOLD;
                end
            end
            MDU_HOLD: begin
                s_done_o[owner_q] = 1'b1;
                s_result_o        = res_q;
                s_err_o           = err_q;
                if (own_flush || own_ack) state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
        // Reset silences every output, including the idle stall level.
        if (s_reset_i) begin
            s_grant_o        = 2'b00;
            s_done_o         = 2'b00;
            s_err_o          = 1'b0;
            s_result_o       = 32'd0;
            s_mdu_compute_o  = 1'b0;
            s_mdu_stall_o    = 1'b0;
            s_mdu_flush_o    = 1'b0;
            s_mdu_function_o = '0;
            s_mdu_op1_o      = 32'd0;
            s_mdu_op2_o      = 32'd0;
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state_q <= MDU_IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            fn_q    <= '0;
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                MDU_IDLE: begin
                    if (|pick) begin
                        owner_q <= pick[1];
                        prio_q  <= ~pick[1];
                        fn_q    <= s_function_i[pick[1]];
                        op1_q   <= s_op1_i[pick[1]];
                        op2_q   <= s_op2_i[pick[1]];
                        cnt_q   <= '0;
                    end
                end
                MDU_BUSY: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!own_flush) begin
                        if (s_mdu_finished_i) begin
                            res_q <= s_mdu_result_i;
                            err_q <= 1'b0;
                        end else if (timeout) begin
                            res_q <= 32'd0;
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_arbiter.sv
// Self-checking bench for mdu_arbiter: per-cycle vector table plus
// a hand-written sequence for function/op2 capture and flush-vs-ack.
import p_hardisc::*;

module tb_mdu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    f_part       fn [2];
    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic [1:0]  flush;
    logic [1:0]  ack;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        err;
    logic [31:0] result;
    logic        m_comp;
    logic        m_stall;
    logic        m_flush;
    f_part       m_fn;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic        m_fin;
    logic [31:0] m_res;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mdu_arbiter #(.P_TIMEOUT(4)) dut (
        .s_clk_i          (clk),
        .s_reset_i        (rst),
        .s_req_i          (req),
        .s_function_i     (fn),
        .s_op1_i          (op1),
        .s_op2_i          (op2),
        .s_flush_i        (flush),
        .s_ack_i          (ack),
        .s_grant_o        (grant),
        .s_done_o         (done),
        .s_err_o          (err),
        .s_result_o       (result),
        .s_mdu_compute_o  (m_comp),
        .s_mdu_stall_o    (m_stall),
        .s_mdu_flush_o    (m_flush),
        .s_mdu_function_o (m_fn),
        .s_mdu_op1_o      (m_op1),
        .s_mdu_op2_o      (m_op2),
        .s_mdu_finished_i (m_fin),
        .s_mdu_result_i   (m_res)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  flush;
        logic [1:0]  ack;
        logic        fin;
        logic [31:0] mres;
        logic [71:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst_v, input logic [1:0] req_v,
        input logic [1:0] fl_v, input logic [1:0] ack_v,
        input logic fin_v, input logic [31:0] mres_v,
        input logic [1:0] g, input logic [1:0] d,
        input logic e, input logic [31:0] r,
        input logic c, input logic s, input logic mf,
        input logic [31:0] o1);
        vec_t v;
        v.rst   = rst_v;
        v.req   = req_v;
        v.flush = fl_v;
        v.ack   = ack_v;
        v.fin   = fin_v;
        v.mres  = mres_v;
        v.exp   = {g, d, e, r, c, s, mf, o1};
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] got,
                         input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic drive(input logic r, input logic [1:0] q,
                         input logic [1:0] f, input logic [1:0] a,
                         input logic fi, input logic [31:0] mr);
        rst   = r;
        req   = q;
        flush = f;
        ack   = a;
        m_fin = fi;
        m_res = mr;
    endtask

    initial begin
        drive(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0);
        fn[0]  = 3'd0;
        fn[1]  = 3'd4;
        op1[0] = 32'd7;
        op2[0] = 32'd6;
        op1[1] = 32'd100;
        op2[1] = 32'd3;

        // single request r0, 7x6 finishes after 3 busy cycles
        vq.push_back(mk(1, 2'b00, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 0, 0, 0));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b01, 0, 0, 1, 42, 2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b01, 0, 1, 0, 0,  2'b00, 2'b01, 0, 42, 0, 1, 0, 0));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 1, 0, 0));
        // both requesting from reset, alternating grants
        vq.push_back(mk(1, 2'b11, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 1, 5,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b11, 0, 1, 0, 0,  2'b00, 2'b01, 0, 5,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b10, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 1, 300, 2'b00, 2'b00, 0, 0, 1, 0, 0, 100));
        vq.push_back(mk(0, 2'b11, 0, 2, 0, 0,  2'b00, 2'b10, 0, 300, 0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 1, 9,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b11, 0, 1, 0, 0,  2'b00, 2'b01, 0, 9,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0,  0, 1, 0, 0));
        // owner flush in busy cycle 2, then finished+flush together
        vq.push_back(mk(1, 2'b11, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b11, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 1, 7));
        vq.push_back(mk(0, 2'b10, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b10, 2, 0, 1, 8,  2'b00, 2'b00, 0, 0,  1, 0, 1, 100));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 1, 0, 0));
        // watchdog timeout at P_TIMEOUT=4, non-owner ack/flush ignored
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  1, 0, 1, 7));
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b00, 2'b01, 1, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b01, 2, 2, 0, 0,  2'b00, 2'b01, 1, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b01, 0, 1, 0, 0,  2'b00, 2'b01, 1, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 1, 0, 0));
        // non-owner ack/flush in hold, then reset asserted in hold
        vq.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0,  0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 1, 77, 2'b00, 2'b00, 0, 0,  1, 0, 0, 7));
        vq.push_back(mk(0, 2'b11, 2, 2, 0, 0,  2'b00, 2'b01, 0, 77, 0, 1, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 0,  2'b00, 2'b01, 0, 77, 0, 1, 0, 0));
        vq.push_back(mk(1, 2'b11, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 0, 0, 0));
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0,  0, 1, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vq[i].rst, vq[i].req, vq[i].flush, vq[i].ack,
                  vq[i].fin, vq[i].mres);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {grant, done, err, result, m_comp, m_stall, m_flush, m_op1},
                  vq[i].exp);
        end

        // r1 alone: function/op2 capture, then flush and ack together in hold
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0);
        @(negedge clk);
        check("seq_grant1", {70'd0, grant}, {70'd0, 2'b10});
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 32'd55);
        @(negedge clk);
        check("seq_fn_op2", {37'd0, m_comp, m_fn, m_op2}, {37'd0, 1'b1, 3'd4, 32'd3});
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 2'b10, 2'b10, 1'b0, 32'd0);
        @(negedge clk);
        check("seq_hold", {38'd0, done, result}, {38'd0, 2'b10, 32'd55});
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0);
        @(negedge clk);
        check("seq_after_flush", {37'd0, done, m_stall, result},
              {37'd0, 2'b00, 1'b1, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_arbiter.md
# mdu_arbiter

Shares one multi-cycle multiply/divide unit (`muldiv`) between the two executing pipelines of the redundant core. Each pipeline's execute stage raises a level request with its function and operands. The arbiter grants one requester at a time with round-robin fairness and registers the winner's operands so the unit sees stable inputs. It returns the result through a done/ack handshake, handles per-requester flushes, and uses a watchdog to abort operations that never finish.

## Interface
Parameters:
- `P_TIMEOUT`, default 40: maximum BUSY cycles before the operation is aborted; must be ≥ 2.

Ports:
- `s_clk_i` in 1: clock.
- `s_reset_i` in 1: asynchronous, active-high reset.
- `s_req_i[2]` in 1 each: requester r wants an MDU operation; level, held until done or flush.
- `s_function_i[2]` in `f_part`: function of requester r.
- `s_op1_i[2]`, `s_op2_i[2]` in 32 each: operands of requester r.
- `s_flush_i[2]` in 1 each: requester r flushed; cancels its request or operation.
- `s_ack_i[2]` in 1 each: requester r consumed its result.
- `s_grant_o[2]` out 1 each: requester r captured this cycle.
- `s_done_o[2]` out 1 each: result for requester r is valid.
- `s_err_o` out 1: valid with `s_done_o`; the operation timed out.
- `s_result_o` out 32: result for the owner.
- `s_mdu_compute_o` out 1: drives the `muldiv` compute input.
- `s_mdu_stall_o` out 1: drives the `muldiv` stall input.
- `s_mdu_flush_o` out 1: drives the `muldiv` flush input.
- `s_mdu_function_o` out `f_part`: registered function.
- `s_mdu_op1_o`, `s_mdu_op2_o` out 32: registered operands.
- `s_mdu_finished_i` in 1: `muldiv` finished.
- `s_mdu_result_i` in 32: `muldiv` result.

## Operation
- States are IDLE, BUSY and HOLD. Registers:
  - `owner` (1 bit).
  - `prio` (1 bit), the preferred requester.
  - Operand/function registers.
  - Result register.
  - `err` register.
  - Watchdog counter of width $clog2(P_TIMEOUT+1).
- IDLE:
  - Eligible requester = `s_req_i[r] & ~s_flush_i[r]`.
  - If exactly one is eligible, grant it. If both are eligible, grant `prio`.
  - On a grant: `s_grant_o[r]`=1 (combinational), capture function/operands/`owner`, set `prio` ← ~r, clear the counter, go to BUSY.
- BUSY:
  - `s_mdu_compute_o`=1; the counter increments each cycle.
  - Priority in BUSY: owner flush, then finished, then timeout (exactly one branch is taken).
  - Owner flush: `s_mdu_flush_o`=1 this cycle, go to IDLE, no done.
  - Else, if `s_mdu_finished_i`: capture the result, `err`←0, go to HOLD.
  - Else, if the counter is P_TIMEOUT-1: `s_mdu_flush_o`=1, result←0, `err`←1, go to HOLD.
- HOLD:
  - `s_done_o[owner]`=1, `s_result_o` = result register, `s_err_o` = `err`.
  - Owner flush: discard the result, go to IDLE (flush wins over ack).
  - Else, if `s_ack_i[owner]`: go to IDLE.
- Non-owner signals:
  - Non-owner flush or ack is ignored in every state.
  - Requests from the non-owner wait.
- `s_mdu_stall_o` = 1 whenever the state is not BUSY.
- Outputs outside their state are 0, including `s_result_o`.

## Timing
- Reset: state IDLE, `prio`=0, `owner`=0, all registers 0, all outputs 0.
- Reset mid-operation returns to IDLE immediately and drops the operation. No `s_mdu_flush_o` is produced; the `muldiv` unit is reset by the same core reset.
- Request in IDLE cycle 0: grant in cycle 0, compute from cycle 1.
- `s_mdu_finished_i` in cycle k: `s_done_o` from cycle k+1.
- Ack in cycle j: IDLE at j+1, where a new grant is possible. This gives one idle bubble between back-to-back operations.
- `s_done_o` stays asserted until ack or flush; there is no timeout in HOLD.
- Watchdog: a unit that never finishes is aborted in BUSY cycle P_TIMEOUT, and done follows on the next cycle.

## Structure
- The state enum is defined in `p_hardisc`.
- `f_part` and `P_TIMEOUT`'s default constant also live in `p_hardisc`.
- One natural sub-module, `rr_pick2`: a combinational two-way round-robin picker (req[2], prio → grant[2]).
- The arbiter instantiates `muldiv` externally. The executor's MDU ports connect through this block.

## Test plan
- Single request, r=0, MULT 7×6, unit finishes after 3 BUSY cycles → grant[0] at cycle 0, done[0] with result 42 at cycle 4; ack → IDLE at cycle 5.
- Both requesting from reset → r0 granted first. After r0 is acked, r1 is granted in the next IDLE cycle. With both held continuously, grants alternate 0,1,0,1.
- Owner flush in BUSY cycle 2 → `s_mdu_flush_o` pulse, no done, IDLE next cycle; the waiting r1 is granted the cycle after.
- `s_mdu_finished_i` and owner flush in the same cycle → no HOLD, no done, flush pulse.
- Unit never finishes, P_TIMEOUT=4 → flush pulse in BUSY cycle 4, done with `s_err_o`=1 and result 0 at cycle 5.
- Non-owner ack/flush during HOLD of r0 → done[0] held, result unchanged; asynchronous reset asserted in HOLD → all outputs 0 immediately.
